// File: rtl/rr_arb_mux4.sv
// rr_arb_mux4: four-requester round-robin arbiter with lock, one-hot data select and a single output register
//   hclk        clock, rising edge
//   hresetn     asynchronous active-low reset
//   req_i       per-requester request
//   lock_i      per-requester lock (honoured only for the current owner)
//   data0_i..3  per-requester data
//   gnt_o       one-hot grant, data captured at this edge
//   out_vld_o   output register holds valid data
//   out_data_o  registered output data
//   out_rdy_i   downstream accepts out_data_o when out_vld_o is high
module rr_arb_mux4 #(
    parameter int DW = 32
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic [3:0]    req_i,
    input  logic [3:0]    lock_i,
    input  logic [DW-1:0] data0_i,
    input  logic [DW-1:0] data1_i,
    input  logic [DW-1:0] data2_i,
    input  logic [DW-1:0] data3_i,
    output logic [3:0]    gnt_o,
    output logic          out_vld_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_rdy_i
);
    logic [1:0]    ptr, own, off, win;
    logic [3:0]    rot;
    logic          own_vld, acc, locked;
    logic [DW-1:0] sel;

    assign acc    = !out_vld_o || out_rdy_i;
    assign locked = own_vld && req_i[own];

    // rot[k] is the request at priority rank k counted from ptr
    always_comb begin
        rot = '0;
        for (int k = 0; k < 4; k++)
            rot[k] = req_i[ptr + 2'(k)];
    end

    assign off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign win   = locked ? own : ptr + off;
    assign gnt_o = (acc && |req_i) ? 4'(1) << win : 4'b0000;

    assign sel = ({DW{gnt_o[0]}} & data0_i) | ({DW{gnt_o[1]}} & data1_i) |
                 ({DW{gnt_o[2]}} & data2_i) | ({DW{gnt_o[3]}} & data3_i);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ptr        <= '0;
            own        <= '0;
            own_vld    <= 1'b0;
            out_vld_o  <= 1'b0;
            out_data_o <= '0;
        end else if (|gnt_o) begin
            out_vld_o  <= 1'b1;
            out_data_o <= sel;
            own_vld    <= lock_i[win];
            own        <= win;
            // a locked grant keeps the rotation where it was
            if (!locked)
                ptr <= win + 2'd1;
        end else begin
            if (out_rdy_i)
                out_vld_o <= 1'b0;
            // owner stopped requesting at an arbitration cycle: release the lock
            if (acc && own_vld && !req_i[own])
                own_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_arb_mux4.sv
// tb_rr_arb_mux4: directed table-driven checks of rr_arb_mux4 plus reset sequences
module tb_rr_arb_mux4;
    localparam logic [31:0] D0 = 32'hA5A5_0000;
    localparam logic [31:0] D1 = 32'h5A5A_1111;
    localparam logic [31:0] D2 = 32'hC3C3_2222;
    localparam logic [31:0] D3 = 32'h3C3C_3333;

    logic        clk, rst_n, rdy, vld;
    logic [3:0]  req, lock, gnt;
    logic [31:0] dat;
    int          errors = 0, checks = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic        rdy;
        logic [3:0]  gnt;
        logic        vld;
        logic [31:0] dat;
    } vec_t;

    vec_t v[25];

    rr_arb_mux4 #(.DW(32)) dut (
        .hclk(clk), .hresetn(rst_n), .req_i(req), .lock_i(lock),
        .data0_i(D0), .data1_i(D1), .data2_i(D2), .data3_i(D3),
        .gnt_o(gnt), .out_vld_o(vld), .out_data_o(dat), .out_rdy_i(rdy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        // round robin from reset
        v[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, D0};
        v[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, D1};
        v[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, D2};
        v[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, D3};
        v[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, D0};
        // walk ptr to 3, then wrap search
        v[5]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, D1};
        v[6]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, D2};
        v[7]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, D2};
        v[8]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, D3};
        // idle drains, data retained
        v[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, D3};
        v[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, D3};
        // lock on index 1
        v[11] = '{4'b1111, 4'b0010, 1'b1, 4'b0001, 1'b1, D0};
        v[12] = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, D1};
        v[13] = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, D1};
        v[14] = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, D1};
        v[15] = '{4'b1101, 4'b0010, 1'b1, 4'b0100, 1'b1, D2};
        // back-pressure
        v[16] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, D2};
        v[17] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, D2};
        v[18] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b1, D2};
        v[19] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, D0};
        v[20] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, D0};
        v[21] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, D0};
        // non-owner lock ignored, then lock taken by index 3
        v[22] = '{4'b1010, 4'b1000, 1'b1, 4'b0010, 1'b1, D1};
        v[23] = '{4'b1010, 4'b1000, 1'b1, 4'b1000, 1'b1, D3};
        v[24] = '{4'b1010, 4'b1000, 1'b1, 4'b1000, 1'b1, D3};

        rst_n = 0; req = 0; lock = 0; rdy = 1;
        #1;
        chk("reset_vld", 32'(vld), 32'(1'b0));
        chk("reset_data", dat, 32'h0);
        chk("reset_gnt", 32'(gnt), 32'(4'b0000));
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            req = v[i].req; lock = v[i].lock; rdy = v[i].rdy;
            #1;
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_vld", i), 32'(vld), 32'(v[i].vld));
            chk($sformatf("vec%0d_data", i), dat, v[i].dat);
        end

        // reset while valid and index 3 owns a lock
        @(negedge clk);
        req = 0; lock = 0; rst_n = 0;
        #1;
        chk("midrst_vld", 32'(vld), 32'(1'b0));
        chk("midrst_data", dat, 32'h0);
        chk("midrst_gnt", 32'(gnt), 32'(4'b0000));
        @(negedge clk);
        rst_n = 1; req = 4'b1111; rdy = 1;
        #1;
        chk("post_rst_gnt", 32'(gnt), 32'(4'b0001));
        @(posedge clk);
        #1;
        chk("post_rst_vld", 32'(vld), 32'(1'b1));
        chk("post_rst_data", dat, D0);
        @(negedge clk);
        #1;
        chk("post_rst_gnt2", 32'(gnt), 32'(4'b0010));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_arb_mux4.md
# rr_arb_mux4

Four-requester round-robin arbiter with an integrated one-hot 4:1 data select and a single-entry output register. It shares one downstream data path (for example, the bridge's APB-side command/write-data path) between four upstream sources. It generates one-hot selects, accepts one requester's data per cycle, and presents the data on a valid/ready output. Requester-side locking lets one source keep ownership across consecutive transfers.

## Interface
Parameters:
- DW, 32, data width of each requester channel and of the output.

Ports:
- hclk  input  1  clock; all state updates on the rising edge.
- hresetn  input  1  asynchronous, active-low reset.
- req_i  input  4  per-requester request; bit i belongs to channel i.
- lock_i  input  4  per-requester lock; keeps ownership with the current owner.
- data0_i..data3_i  input  DW each  per-requester data; must be stable while the matching req_i bit is high.
- gnt_o  output  4  one-hot grant; bit i high means data{i}_i is captured at this clock edge.
- out_vld_o  output  1  output register holds valid data.
- out_data_o  output  DW  registered output data.
- out_rdy_i  input  1  downstream accepts out_data_o when out_vld_o=1 and out_rdy_i=1.

## Operation
- Accept condition: acc = (out_vld_o==0) | out_rdy_i. Arbitration happens only when acc=1; otherwise gnt_o=0.
- Round-robin pointer ptr[1:0] (reset 0) gives the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4. The first requester found with req_i=1 wins.
- On a grant to index w: ptr <= w+1 (mod 4), unless the grant was issued under lock (see below).
- Lock state: own_vld (reset 0) and own[1:0] (reset 0).
  - Each grant to w sets own_vld <= lock_i[w] and own <= w.
  - While own_vld=1 and req_i[own]=1, requester own wins every arbitration regardless of ptr, and ptr is not advanced.
  - When own_vld=1 and req_i[own]=0 at an arbitration cycle, own_vld clears. Normal round-robin from ptr applies in that same cycle.
  - lock_i bits of non-owners are ignored.
- gnt_o is combinational from req_i, lock state, ptr and acc. It is at most one-hot and zero when no req_i bit is high.
- Data select is a one-hot AND-OR of data0_i..data3_i gated by gnt_o. The result is registered into out_data_o when |gnt_o.
- Output register update per edge:
  - if |gnt_o: out_vld_o <= 1 and out_data_o <= selected data;
  - else if out_rdy_i: out_vld_o <= 0 and out_data_o holds;
  - else: both hold.
- Requesters may drop req_i before being granted, with no side effect. A requester keeping req_i high after its grant requests again.

## Timing
- Reset values: out_vld_o=0, out_data_o=0, gnt_o=0 (no req), ptr=0, own_vld=0, own=0.
- Latency: req_i high at cycle N with acc=1 gives gnt_o high in cycle N, and out_vld_o/out_data_o valid in cycle N+1.
- Throughput: one transfer per cycle while out_rdy_i=1. Simultaneous drain and capture in one cycle is required (out_vld_o stays 1 with new data).
- Back-pressure: out_vld_o=1 and out_rdy_i=0 forces gnt_o=0, and out_data_o must not change.
- Fairness bound: with all four requesting and no lock, each index is granted once every 4 grants.
- Reset mid-operation: asserting hresetn low immediately clears out_vld_o, ptr and the lock state, and discards any pending output data.

## Test plan
- All four req_i=4'b1111, out_rdy_i=1, no lock, from reset -> gnt_o sequence 0001, 0010, 0100, 1000, 0001; out_data_o follows data0..data3 one cycle later.
- req_i=4'b0100 only, after ptr=3 -> gnt_o=0100, ptr becomes 3; then req_i=4'b1001 -> gnt_o=1000.
- req_i=4'b1111, lock_i=4'b0010, first grant to index 1 -> gnt_o=0010 repeats every cycle. When req_i[1] drops, the next grant is 0100 (ptr=2).
- out_vld_o=1, out_rdy_i=0 for 3 cycles with req_i=4'b0001 -> gnt_o=0 and out_data_o stable. When out_rdy_i rises, gnt_o=0001 in that cycle and the new data appears next cycle.
- req_i=0 with out_rdy_i=1 -> out_vld_o falls after one cycle and out_data_o retains its last value.
- Assert hresetn low while out_vld_o=1 and a lock is owned -> out_vld_o=0 and out_data_o=0 immediately. After release with req_i=4'b1111, the first grant is 0001.
